// File: rtl/num_to_digits_pkg.sv
// Shared types and defaults for the digit extractor: state encoding, digit width,
// and the default radix and digit count.
package num_to_digits_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int DIGIT_W   = 4;
  localparam int BASE_DEF  = 10;
  localparam int NDIG_DEF  = 5;

endpackage

// File: rtl/num_to_digits_div_algo.sv
// Combinational unsigned divider: q = n / d, r = n % d in the same cycle.
// Zero latency; no flow control, and the caller guarantees d != 0.
module div_algo #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  assign q = n / d;
  assign r = n % d;

endmodule

// File: rtl/num_to_digits.sv
// Splits a number into BASE digits with one division per clock; done pulses d+1 cycles after start.
// No backpressure: start is taken only in IDLE, and results hold until the next accepted start.
module num_to_digits
  import num_to_digits_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BASE  = BASE_DEF,
  parameter int NDIG  = NDIG_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [WIDTH-1:0]        num,
  output logic                    busy,
  output logic                    done,
  output logic [DIGIT_W*NDIG-1:0] digits,
  output logic [2:0]              ndigits
);

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [2:0]       idx;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             rem_hi_unused;

  div_algo #(.WIDTH(WIDTH)) u_div (
    .n (work),
    .d (WIDTH'(BASE)),
    .q (q),
    .r (r)
  );

  // The remainder is always below BASE (at most 16), so only the low digit bits carry information.
  assign rem_hi_unused = &{1'b0, r[WIDTH-1:DIGIT_W]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      work    <= '0;
      idx     <= '0;
      digits  <= '0;
      ndigits <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            work   <= num;
            digits <= '0;
            idx    <= '0;
            busy   <= 1'b1;
            state  <= DIVIDE;
          end
        end
        DIVIDE: begin
          for (int i = 0; i < NDIG; i++) begin
            if (idx == 3'(i)) digits[DIGIT_W*i +: DIGIT_W] <= r[DIGIT_W-1:0];
          end
          work    <= q;
          ndigits <= idx + 3'd1;
          idx     <= idx + 3'd1;
          // Stop on the last significant digit, or when the digit field is full.
          if (q == '0 || idx == 3'(NDIG - 1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_num_to_digits.sv
// Randomized and directed checks of num_to_digits against an arithmetic decimal model.
module tb_num_to_digits;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] num;
  logic        busy;
  logic        done;
  logic [19:0] digits;
  logic [2:0]  ndigits;

  int checks;
  int errors;

  num_to_digits dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .num     (num),
    .busy    (busy),
    .done    (done),
    .digits  (digits),
    .ndigits (ndigits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal digits via repeated arithmetic; at least one digit, at most five.
  function automatic void ref_conv(input int v, output logic [19:0] dg, output int nd);
    int x;
    x  = v;
    dg = '0;
    nd = 0;
    do begin
      dg = dg | (20'(x % 10) << (4 * nd));
      x  = x / 10;
      nd++;
    end while (x != 0 && nd < 5);
  endfunction

  // Launches one conversion and stops at the negedge of the done cycle.
  task automatic run_conv(input logic [15:0] val, output int busy_cyc, output int lat,
                          output bit got_done);
    @(negedge clk);
    num   = val;
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    num      = 16'($urandom);
    busy_cyc = 0;
    lat      = 0;
    got_done = 1'b0;
    for (int i = 0; i < 20 && !got_done; i++) begin
      if (busy) busy_cyc++;
      if (done) begin
        got_done = 1'b1;
        lat      = i;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; num = '0;
    #1;
    checks++;
    if ({busy, done, digits, ndigits} !== 25'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b digits=%h ndigits=%0d, required all 0",
               busy, done, digits, ndigits);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, digits, ndigits} !== 25'd0) begin
      errors++;
      $display("FAIL reset_release: busy=%b done=%b digits=%h ndigits=%0d, required all 0",
               busy, done, digits, ndigits);
    end
  endtask

  task automatic test_basic;
    int bc, lat; bit gd;
    run_conv(16'd100, bc, lat, gd);
    checks++;
    if (!gd || bc != 3 || lat != 3) begin
      errors++;
      $display("FAIL basic_timing: done=%b busy_cycles=%0d latency=%0d, required 1/3/3", gd, bc, lat);
    end
    checks++;
    if (digits !== 20'h00100 || ndigits !== 3'd3) begin
      errors++;
      $display("FAIL basic_value: digits=%h ndigits=%0d, required 00100/3", digits, ndigits);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || digits !== 20'h00100 || ndigits !== 3'd3) begin
      errors++;
      $display("FAIL basic_hold: done=%b busy=%b digits=%h ndigits=%0d, required 0/0/00100/3",
               done, busy, digits, ndigits);
    end
  endtask

  task automatic test_reuse;
    int bc, lat; bit gd;
    run_conv(16'd9995, bc, lat, gd);
    checks++;
    if (!gd || bc != 4 || digits !== 20'h09995 || ndigits !== 3'd4) begin
      errors++;
      $display("FAIL reuse_9995: done=%b busy_cycles=%0d digits=%h ndigits=%0d, required 1/4/09995/4",
               gd, bc, digits, ndigits);
    end
    run_conv(16'd354, bc, lat, gd);
    checks++;
    if (!gd || bc != 3 || digits !== 20'h00354 || ndigits !== 3'd3) begin
      errors++;
      $display("FAIL reuse_354: done=%b busy_cycles=%0d digits=%h ndigits=%0d, required 1/3/00354/3",
               gd, bc, digits, ndigits);
    end
  endtask

  task automatic test_extremes;
    int bc, lat; bit gd;
    run_conv(16'd65535, bc, lat, gd);
    checks++;
    if (!gd || lat != 5 || digits !== 20'h65535 || ndigits !== 3'd5) begin
      errors++;
      $display("FAIL max_value: done=%b latency=%0d digits=%h ndigits=%0d, required 1/5/65535/5",
               gd, lat, digits, ndigits);
    end
    run_conv(16'd0, bc, lat, gd);
    checks++;
    if (!gd || lat != 1 || bc != 1 || digits !== 20'h0 || ndigits !== 3'd1) begin
      errors++;
      $display("FAIL zero_value: done=%b latency=%0d busy_cycles=%0d digits=%h ndigits=%0d, required 1/1/1/0/1",
               gd, lat, bc, digits, ndigits);
    end
  endtask

  task automatic test_ignore_start;
    bit gd;
    int lat;
    @(negedge clk);
    num = 16'd100; start = 1'b1;
    @(negedge clk);
    num = 16'd7;              // start stays high through DIVIDE and DONE
    gd = 1'b0; lat = 0;
    for (int i = 0; i < 20 && !gd; i++) begin
      if (done) begin gd = 1'b1; lat = i; end
      else @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (!gd || lat != 3 || digits !== 20'h00100 || ndigits !== 3'd3) begin
      errors++;
      $display("FAIL ignore_start: done=%b latency=%0d digits=%h ndigits=%0d, required 1/3/00100/3",
               gd, lat, digits, ndigits);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || digits !== 20'h00100) begin
      errors++;
      $display("FAIL ignore_no_queue: busy=%b digits=%h, required 0/00100", busy, digits);
    end
  endtask

  task automatic test_reset_mid;
    int bc, lat; bit gd;
    @(negedge clk);
    num = 16'd9995; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++;
    if (busy !== 1'b1 || digits !== 20'h00095) begin
      errors++;
      $display("FAIL mid_partial: busy=%b digits=%h, required 1/00095", busy, digits);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, digits, ndigits} !== 25'd0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b done=%b digits=%h ndigits=%0d, required all 0",
               busy, done, digits, ndigits);
    end
    @(negedge clk);
    rst = 1'b0;
    run_conv(16'd23, bc, lat, gd);
    checks++;
    if (!gd || bc != 2 || digits !== 20'h00023 || ndigits !== 3'd2) begin
      errors++;
      $display("FAIL after_reset: done=%b busy_cycles=%0d digits=%h ndigits=%0d, required 1/2/00023/2",
               gd, bc, digits, ndigits);
    end
  endtask

  task automatic test_back_to_back;
    int pulses, run_len;
    @(negedge clk);
    num = 16'd354; start = 1'b1;
    pulses = 0; run_len = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        run_len++;
        pulses++;
        checks++;
        if (run_len > 1 || digits !== 20'h00354 || ndigits !== 3'd3) begin
          errors++;
          $display("FAIL b2b_pulse: width=%0d digits=%h ndigits=%0d, required 1/00354/3",
                   run_len, digits, ndigits);
        end
      end else begin
        run_len = 0;
      end
    end
    start = 1'b0;
    // Accept, three divides, DONE: a new result every five cycles.
    checks++;
    if (pulses < 7) begin
      errors++;
      $display("FAIL b2b_count: pulses=%0d, required at least 7", pulses);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_random;
    int bc, lat, nd; bit gd;
    logic [19:0] dg;
    logic [15:0] v;
    for (int k = 0; k < 30; k++) begin
      v = (k % 3 == 0) ? 16'($urandom_range(0, 99)) : 16'($urandom);
      ref_conv(int'(v), dg, nd);
      run_conv(v, bc, lat, gd);
      checks++;
      if (!gd || lat != nd || bc != nd || digits !== dg || ndigits !== 3'(nd)) begin
        errors++;
        $display("FAIL random num=%0d: done=%b latency=%0d busy=%0d digits=%h ndigits=%0d, required latency=%0d digits=%h ndigits=%0d",
                 v, gd, lat, bc, digits, ndigits, nd, dg, nd);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_reuse();
    test_extremes();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
